// File: rtl/cv_ctrl_pkg.sv
// cv_ctrl_pkg: shared constants and helpers for the ColecoVision controller
// port front end.
//   - JB_* : bit positions inside one 20-bit MiSTer joystick vector.
//   - cv_key_*_c : keypad codes driven on {p1,p2,p3,p4} (active-low pins).
//   - quad_next / quad_prev : Gray-coded spinner phase stepping, {A,B}.
package cv_ctrl_pkg;

  localparam int JOY_W     = 20;
  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_FIRE1  = 4;
  localparam int JB_FIRE2  = 5;
  localparam int JB_STAR   = 6;
  localparam int JB_HASH   = 7;
  localparam int JB_DIGIT0 = 8;
  localparam int JB_PURPLE = 18;
  localparam int JB_BLUE   = 19;

  localparam logic [3:0] cv_key_0_c      = 4'b0011;
  localparam logic [3:0] cv_key_1_c      = 4'b1110;
  localparam logic [3:0] cv_key_2_c      = 4'b1101;
  localparam logic [3:0] cv_key_3_c      = 4'b0110;
  localparam logic [3:0] cv_key_4_c      = 4'b0001;
  localparam logic [3:0] cv_key_5_c      = 4'b1001;
  localparam logic [3:0] cv_key_6_c      = 4'b0111;
  localparam logic [3:0] cv_key_7_c      = 4'b1100;
  localparam logic [3:0] cv_key_8_c      = 4'b1000;
  localparam logic [3:0] cv_key_9_c      = 4'b1011;
  localparam logic [3:0] cv_key_star_c   = 4'b1010;
  localparam logic [3:0] cv_key_hash_c   = 4'b0101;
  localparam logic [3:0] cv_key_purple_c = 4'b0100;
  localparam logic [3:0] cv_key_blue_c   = 4'b0010;
  localparam logic [3:0] cv_key_none_c   = 4'b1111;

  // Idle quadrature phase: both spinner pins high.
  localparam logic [1:0] QUAD_IDLE = 2'b11;

  function automatic logic [3:0] cv_digit_code(input int d);
    case (d)
      0:       return cv_key_0_c;
      1:       return cv_key_1_c;
      2:       return cv_key_2_c;
      3:       return cv_key_3_c;
      4:       return cv_key_4_c;
      5:       return cv_key_5_c;
      6:       return cv_key_6_c;
      7:       return cv_key_7_c;
      8:       return cv_key_8_c;
      9:       return cv_key_9_c;
      default: return cv_key_none_c;
    endcase
  endfunction

  // Forward rotation: 11 -> 10 -> 00 -> 01 -> 11.
  function automatic logic [1:0] quad_next(input logic [1:0] ph);
    case (ph)
      2'b11:   return 2'b10;
      2'b10:   return 2'b00;
      2'b00:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // Reverse rotation: 11 -> 01 -> 00 -> 10 -> 11.
  function automatic logic [1:0] quad_prev(input logic [1:0] ph);
    case (ph)
      2'b11:   return 2'b01;
      2'b01:   return 2'b00;
      2'b00:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/cv_spinner_quad.sv
// cv_spinner_quad: Super Action spinner quadrature generator for one port.
//   clk_i, reset_n_i : system clock, async active-low reset
//   clk_en_i         : tick enable counted by the step divider
//   en_i             : spinner mode; low clears accumulator/divider, phase idle
//   stb_i, d_i       : signed 8-bit delta, qualified by a one-cycle strobe
//   phase_o          : current Gray phase {A,B}; doubles as the state readout
// Handshake: stb_i is a pure one-cycle qualifier with no back-pressure; every
// strobe seen while en_i=1 is consumed in the cycle it arrives.
module cv_spinner_quad
  import cv_ctrl_pkg::*;
#(
  parameter int ACC_W    = 8,
  parameter int STEP_DIV = 256
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_i,
  input  logic       en_i,
  input  logic       stb_i,
  input  logic [7:0] d_i,
  output logic [1:0] phase_o
);

  localparam int TICK_W = $clog2(STEP_DIV);
  // Headroom so acc + delta - 1 can never overflow before saturation.
  localparam int SUM_W  = ((ACC_W > 8) ? ACC_W : 8) + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

  logic signed [ACC_W-1:0] acc_q;
  logic        [TICK_W-1:0] tick_q;
  logic        [1:0]        phase_q;

  logic                    wrap;
  logic                    acc_pos;
  logic                    acc_neg;
  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] d_ext;
  logic signed [SUM_W-1:0] step_d;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_d;

  always_comb begin
    wrap    = clk_en_i && (tick_q == TICK_W'(STEP_DIV - 1));
    acc_neg = acc_q[ACC_W-1];
    acc_pos = !acc_q[ACC_W-1] && (acc_q != '0);
    acc_ext = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    d_ext   = stb_i ? {{(SUM_W-8){d_i[7]}}, d_i} : '0;
    // Each wrap moves the accumulator one unit toward zero.
    step_d  = '0;
    if (wrap && acc_pos)      step_d = SUM_W'(1);
    else if (wrap && acc_neg) step_d = '1;
    sum = acc_ext + d_ext - step_d;
    if (sum > SAT_MAX)      acc_d = SAT_MAX[ACC_W-1:0];
    else if (sum < SAT_MIN) acc_d = SAT_MIN[ACC_W-1:0];
    else                    acc_d = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q   <= '0;
      tick_q  <= '0;
      phase_q <= QUAD_IDLE;
    end else if (!en_i) begin
      acc_q   <= '0;
      tick_q  <= '0;
      phase_q <= QUAD_IDLE;
    end else begin
      acc_q <= acc_d;
      if (clk_en_i) tick_q <= wrap ? '0 : tick_q + TICK_W'(1);
      // Direction comes from the pre-update accumulator: one Gray edge per wrap.
      if (wrap && acc_pos)      phase_q <= quad_next(phase_q);
      else if (wrap && acc_neg) phase_q <= quad_prev(phase_q);
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/cv_ctrl_ports.sv
// cv_ctrl_ports: ColecoVision controller-port front end.
//   clk_i, reset_n_i, clk_en_i : system clock, async active-low reset, 10.7 MHz enable
//   swap_i                     : exchange ports 0 and 1
//   joy_i                      : NUM_PORTS x 20 active-high button vectors
//   spin_en_i/spin_d_i/spin_stb_i : per-port spinner mode, delta, strobe
//   sel_p5_n_i / sel_p8_n_i    : console keypad / joystick select strobes
//   ctrl_o {p1..p4}, ctrl_p6_o : registered active-low controller pins
//   ctrl_p7_o / ctrl_p9_o      : spinner quadrature A / B
// reset_n_i is expected to be release-synchronised to clk_i upstream.
module cv_ctrl_ports
  import cv_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ACC_W     = 8,
  parameter int STEP_DIV  = 256
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clk_en_i,
  input  logic                   swap_i,
  input  logic [NUM_PORTS*20-1:0] joy_i,
  input  logic [NUM_PORTS-1:0]   spin_en_i,
  input  logic [NUM_PORTS*8-1:0] spin_d_i,
  input  logic [NUM_PORTS-1:0]   spin_stb_i,
  input  logic [NUM_PORTS-1:0]   sel_p5_n_i,
  input  logic [NUM_PORTS-1:0]   sel_p8_n_i,
  output logic [NUM_PORTS*4-1:0] ctrl_o,
  output logic [NUM_PORTS-1:0]   ctrl_p6_o,
  output logic [NUM_PORTS-1:0]   ctrl_p7_o,
  output logic [NUM_PORTS-1:0]   ctrl_p9_o
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // Partner port used when swap_i is set; only ports 0 and 1 ever swap.
    localparam int ALT = (NUM_PORTS > 1 && p < 2) ? (1 - p) : p;

    logic [JOY_W-1:0] joy_sel;
    logic             spin_en_sel;
    logic             spin_stb_sel;
    logic [7:0]       spin_d_sel;
    logic [3:0]       key_half;
    logic [3:0]       joy_half;
    logic             key_p6;
    logic             joy_p6;
    logic [3:0]       pins_q;
    logic             p6_q;
    logic [1:0]       phase;
    logic             unused_fire2;

    always_comb begin
      joy_sel      = swap_i ? joy_i[ALT*JOY_W +: JOY_W] : joy_i[p*JOY_W +: JOY_W];
      spin_en_sel  = swap_i ? spin_en_i[ALT]            : spin_en_i[p];
      spin_stb_sel = swap_i ? spin_stb_i[ALT]           : spin_stb_i[p];
      spin_d_sel   = swap_i ? spin_d_i[ALT*8 +: 8]      : spin_d_i[p*8 +: 8];
    end

    // Fire2 has no pin on this connector.
    assign unused_fire2 = joy_sel[JB_FIRE2];

    always_comb begin
      key_half = 4'b1111;
      key_p6   = 1'b1;
      if (!sel_p5_n_i[p]) begin
        // Lowest priority assigned first so higher-priority keys overwrite.
        key_half = cv_key_none_c;
        if (joy_sel[JB_BLUE])   key_half = cv_key_blue_c;
        if (joy_sel[JB_PURPLE]) key_half = cv_key_purple_c;
        if (joy_sel[JB_HASH])   key_half = cv_key_hash_c;
        if (joy_sel[JB_STAR])   key_half = cv_key_star_c;
        for (int d = 9; d >= 0; d--) begin
          if (joy_sel[JB_DIGIT0 + d]) key_half = cv_digit_code(d);
        end
        key_p6 = ~joy_sel[JB_BLUE];
      end
      joy_half = 4'b1111;
      joy_p6   = 1'b1;
      if (!sel_p8_n_i[p]) begin
        joy_half = ~{joy_sel[JB_UP], joy_sel[JB_DOWN], joy_sel[JB_LEFT], joy_sel[JB_RIGHT]};
        joy_p6   = ~joy_sel[JB_FIRE1];
      end
    end

    // Both selects low behaves like the console's wired-AND of the two halves.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        pins_q <= 4'b1111;
        p6_q   <= 1'b1;
      end else begin
        pins_q <= key_half & joy_half;
        p6_q   <= key_p6 & joy_p6;
      end
    end

    cv_spinner_quad #(
      .ACC_W    (ACC_W),
      .STEP_DIV (STEP_DIV)
    ) u_spin (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clk_en_i  (clk_en_i),
      .en_i      (spin_en_sel),
      .stb_i     (spin_stb_sel),
      .d_i       (spin_d_sel),
      .phase_o   (phase)
    );

    assign ctrl_o[p*4 +: 4] = pins_q;
    assign ctrl_p6_o[p]     = p6_q;
    assign ctrl_p7_o[p]     = phase[1];
    assign ctrl_p9_o[p]     = phase[0];
  end

endmodule

// File: tb/tb_cv_ctrl_ports.sv
module tb_cv_ctrl_ports;

  localparam int NP   = 2;
  localparam int SD   = 4;
  localparam int AW   = 8;
  localparam int AMAX = 127;
  localparam int OW   = NP * 4 + NP * 3;

  logic              clk_i;
  logic              reset_n_i;
  logic              clk_en_i;
  logic              swap_i;
  logic [NP*20-1:0]  joy_i;
  logic [NP-1:0]     spin_en_i;
  logic [NP*8-1:0]   spin_d_i;
  logic [NP-1:0]     spin_stb_i;
  logic [NP-1:0]     sel_p5_n_i;
  logic [NP-1:0]     sel_p8_n_i;
  logic [NP*4-1:0]   ctrl_o;
  logic [NP-1:0]     ctrl_p6_o;
  logic [NP-1:0]     ctrl_p7_o;
  logic [NP-1:0]     ctrl_p9_o;

  cv_ctrl_ports #(
    .NUM_PORTS (NP),
    .ACC_W     (AW),
    .STEP_DIV  (SD)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clk_en_i   (clk_en_i),
    .swap_i     (swap_i),
    .joy_i      (joy_i),
    .spin_en_i  (spin_en_i),
    .spin_d_i   (spin_d_i),
    .spin_stb_i (spin_stb_i),
    .sel_p5_n_i (sel_p5_n_i),
    .sel_p8_n_i (sel_p8_n_i),
    .ctrl_o     (ctrl_o),
    .ctrl_p6_o  (ctrl_p6_o),
    .ctrl_p7_o  (ctrl_p7_o),
    .ctrl_p9_o  (ctrl_p9_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [OW-1:0] exp_q[$];

  // Keypad priority table: joystick bit and its code, first match wins.
  int         key_bit  [14] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 6, 7, 18, 19};
  logic [3:0] key_code [14] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001,
                                4'b1001, 4'b0111, 4'b1100, 4'b1000, 4'b1011,
                                4'b1010, 4'b0101, 4'b0100, 4'b0010};
  // Forward quadrature order; position index advances +1 per forward step.
  logic [1:0] gray_c [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

  int m_acc  [NP];
  int m_tick [NP];
  int m_pos  [NP];

  function automatic logic [4:0] key_model(input logic sel5, input logic sel8,
                                           input logic [19:0] j);
    logic [3:0] kh, jh;
    logic       kp, jp, found;
    kh = 4'b1111; kp = 1'b1; jh = 4'b1111; jp = 1'b1; found = 1'b0;
    if (!sel5) begin
      kh = 4'b1111;
      for (int i = 0; i < 14; i++) begin
        if (!found && j[key_bit[i]]) begin
          kh = key_code[i];
          found = 1'b1;
        end
      end
      kp = ~j[19];
    end
    if (!sel8) begin
      jh = ~{j[3], j[2], j[1], j[0]};
      jp = ~j[4];
    end
    return {kh & jh, kp & jp};
  endfunction

  // Reference model: on every clock edge compute what the pins must show next.
  always @(posedge clk_i) begin : model
    logic [OW-1:0] e;
    logic [4:0]    ko;
    int            src, d, dir;
    bit            wrap;
    e = '1;
    if (!reset_n_i) begin
      for (int p = 0; p < NP; p++) begin
        m_acc[p] = 0; m_tick[p] = 0; m_pos[p] = 0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        src = (swap_i && p < 2) ? 1 - p : p;
        ko = key_model(sel_p5_n_i[p], sel_p8_n_i[p], joy_i[src*20 +: 20]);
        e[2*NP + NP + p*4 +: 4] = ko[4:1];
        e[2*NP + p] = ko[0];
        if (!spin_en_i[src]) begin
          m_acc[p] = 0; m_tick[p] = 0; m_pos[p] = 0;
        end else begin
          wrap = clk_en_i && (m_tick[p] == SD - 1);
          dir  = (m_acc[p] > 0) ? 1 : ((m_acc[p] < 0) ? -1 : 0);
          d    = spin_stb_i[src] ? int'($signed(spin_d_i[src*8 +: 8])) : 0;
          if (clk_en_i) m_tick[p] = wrap ? 0 : m_tick[p] + 1;
          if (wrap) begin
            m_pos[p] = (m_pos[p] + dir + 4) % 4;
            m_acc[p] = m_acc[p] - dir;
          end
          m_acc[p] = m_acc[p] + d;
          if (m_acc[p] > AMAX)  m_acc[p] = AMAX;
          if (m_acc[p] < -AMAX) m_acc[p] = -AMAX;
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      e[NP + p] = gray_c[m_pos[p]][1];
      e[p]      = gray_c[m_pos[p]][0];
    end
    exp_q.push_back(e);
  end

  // Monitor: pins are valid every cycle; compare away from the active edge.
  always @(negedge clk_i) begin : monitor
    logic [OW-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {ctrl_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    clk_en_i   = 1'b1;
    swap_i     = 1'b0;
    joy_i      = '0;
    spin_en_i  = '0;
    spin_d_i   = '0;
    spin_stb_i = '0;
    sel_p5_n_i = '1;
    sel_p8_n_i = '1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ctrl_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o});
  endfunction

  function automatic logic [31:0] phase_of(input int p);
    return 32'({ctrl_p7_o[p], ctrl_p9_o[p]});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n_i = 1'b1;
    idle_inputs();
    #2 reset_n_i = 1'b0;
    step(3);
    check("reset_state", all_outs(), 32'h3fff);
    reset_n_i = 1'b1;
    step(1);

    // Keypad priority: digits 1 and 9 -> digit 1 wins.
    sel_p5_n_i[0] = 1'b0;
    joy_i[9] = 1'b1; joy_i[17] = 1'b1;
    step(1);
    check("key_prio_ctrl", ctrl_o[3:0], 4'b1110);
    check("key_prio_p6", ctrl_p6_o[0], 1'b1);
    check("key_other_port_idle", ctrl_o[7:4], 4'b1111);
    joy_i = '0; joy_i[19] = 1'b1;
    step(1);
    check("key_blue_ctrl", ctrl_o[3:0], 4'b0010);
    check("key_blue_p6", ctrl_p6_o[0], 1'b0);

    // Joystick half, then wired-AND of both halves.
    idle_inputs();
    sel_p8_n_i[0] = 1'b0;
    joy_i[3] = 1'b1; joy_i[4] = 1'b1;
    step(1);
    check("joy_up_ctrl", ctrl_o[3:0], 4'b0111);
    check("joy_fire_p6", ctrl_p6_o[0], 1'b0);
    sel_p5_n_i[0] = 1'b0;
    joy_i = '0; joy_i[8] = 1'b1; joy_i[3] = 1'b1;
    step(1);
    check("wired_and_ctrl", ctrl_o[3:0], 4'b0011);
    check("wired_and_p6", ctrl_p6_o[0], 1'b1);

    // Swap: digit 5 on physical port 1 shows up on logical port 0.
    idle_inputs();
    swap_i = 1'b1;
    joy_i[20 + 13] = 1'b1;
    sel_p5_n_i[0] = 1'b0;
    step(1);
    check("swap_port0", ctrl_o[3:0], 4'b1001);
    check("swap_port1", ctrl_o[7:4], 4'b1111);

    // Spinner forward: +3 gives three forward edges, 4 cycles apart.
    idle_inputs();
    step(1);
    spin_en_i[0] = 1'b1; spin_stb_i[0] = 1'b1; spin_d_i[7:0] = 8'd3;
    step(1);
    spin_stb_i[0] = 1'b0;
    step(2);
    check("fwd_before_wrap", phase_of(0), 2'b11);
    step(1);
    check("fwd_step1", phase_of(0), 2'b10);
    step(4);
    check("fwd_step2", phase_of(0), 2'b00);
    step(4);
    check("fwd_step3", phase_of(0), 2'b01);
    step(8);
    check("fwd_hold", phase_of(0), 2'b01);

    // Spinner reverse with saturation, then disable.
    spin_en_i[0] = 1'b0;
    step(1);
    spin_en_i[0] = 1'b1; spin_stb_i[0] = 1'b1; spin_d_i[7:0] = 8'h9C;
    step(2);
    spin_stb_i[0] = 1'b0;
    step(1);
    check("rev_before_wrap", phase_of(0), 2'b11);
    step(1);
    check("rev_step1", phase_of(0), 2'b01);
    spin_en_i[0] = 1'b0;
    step(1);
    check("disable_idle", phase_of(0), 2'b11);

    // Divider does not advance while clk_en_i is low.
    idle_inputs();
    clk_en_i = 1'b0;
    spin_en_i[1] = 1'b1; spin_stb_i[1] = 1'b1; spin_d_i[15:8] = 8'd2;
    step(1);
    spin_stb_i[1] = 1'b0;
    step(8);
    check("clken_low_hold", phase_of(1), 2'b11);

    // Positive saturation: +100 +100 -> 127 edges, ending at phase 01.
    spin_en_i[1] = 1'b0; clk_en_i = 1'b1;
    step(1);
    spin_en_i[1] = 1'b1; spin_stb_i[1] = 1'b1; spin_d_i[15:8] = 8'd100;
    step(2);
    spin_stb_i[1] = 1'b0;
    step(518);
    check("sat_pos_final", phase_of(1), 2'b01);

    // Asynchronous reset in the middle of a step sequence.
    idle_inputs();
    spin_en_i[0] = 1'b1; spin_stb_i[0] = 1'b1; spin_d_i[7:0] = 8'd100;
    step(1);
    spin_stb_i[0] = 1'b0;
    step(4);
    check("pre_reset_phase", phase_of(0), 2'b10);
    #1 reset_n_i = 1'b0;
    #1 check("async_reset", all_outs(), 32'h3fff);
    step(3);
    reset_n_i = 1'b1;
    step(10);
    check("idle_after_reset", all_outs(), 32'h3fff);

    // Randomised traffic checked by the scoreboard.
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 15) == 0) swap_i = ~swap_i;
      clk_en_i = 1'($urandom_range(0, 1));
      for (int p = 0; p < NP; p++) begin
        joy_i[p*20 +: 20]   = 20'($urandom()) & 20'($urandom()) & 20'($urandom());
        sel_p5_n_i[p]       = 1'($urandom_range(0, 1));
        sel_p8_n_i[p]       = 1'($urandom_range(0, 1));
        spin_en_i[p]        = ($urandom_range(0, 63) != 0);
        spin_stb_i[p]       = ($urandom_range(0, 3) == 0);
        spin_d_i[p*8 +: 8]  = 8'($urandom());
      end
      step(1);
    end

    idle_inputs();
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cv_ctrl_ports.md
Name: cv_ctrl_ports

Overview:
- Parametrised ColecoVision controller-port front end that replaces the fixed two-player keypad/joystick encoder in the top level.
- Maps NUM_PORTS MiSTer joystick vectors onto the CV controller pins, with a registered keypad encoder driven by the console's pin-5/pin-8 select strobes.
- Adds a Super Action spinner quadrature generator per port on pins 7/9.
- Sits between hps_io joystick/keyboard mixing and cv_console ctrl_p* ports.

Parameters:
- NUM_PORTS, 2, number of controller ports (1..4).
- ACC_W, 8, width of the signed per-port spinner step accumulator.
- STEP_DIV, 256, clk_en_i ticks per quadrature edge; minimum 2.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- clk_en_i  in  1  10.7 MHz clock enable.
- swap_i  in  1  exchange ports 0 and 1 (ignored when NUM_PORTS=1).
- joy_i  in  NUM_PORTS*20  per-port active-high buttons. Bit map: 0 right, 1 left, 2 down, 3 up, 4 fire1, 5 fire2, 6 star, 7 hash, 8..17 digits 0..9, 18 purple, 19 blue.
- spin_en_i  in  NUM_PORTS  spinner mode enable per port.
- spin_d_i  in  NUM_PORTS*8  signed spinner delta per port.
- spin_stb_i  in  NUM_PORTS  one-cycle strobe qualifying spin_d_i.
- sel_p5_n_i  in  NUM_PORTS  keypad select (console ctrl_p5), active-low.
- sel_p8_n_i  in  NUM_PORTS  joystick select (console ctrl_p8), active-low.
- ctrl_o  out  NUM_PORTS*4  pins {p1,p2,p3,p4} per port, active-low.
- ctrl_p6_o  out  NUM_PORTS  fire pin, active-low.
- ctrl_p7_o  out  NUM_PORTS  quadrature A.
- ctrl_p9_o  out  NUM_PORTS  quadrature B.

Behaviour:
- Reset (async assert, sync release): ctrl_o all 1, ctrl_p6_o all 1, quadrature phase 2'b11 so p7=p9=1, accumulators 0, tick counters 0.
- Port mapping: when swap_i=1, logical port 0 uses joy_i/spin_* of port 1 and vice versa. Ports >=2 are never swapped.
- Keypad half, when sel_p5_n=0:
  - Priority encode, first set wins: 0,1,...,9,star,hash,purple,blue.
  - Codes: 0=0011, 1=1110, 2=1101, 3=0110, 4=0001, 5=1001, 6=0111, 7=1100, 8=1000, 9=1011, star=1010, hash=0101, purple=0100, blue=0010, none=1111.
  - p6 half = ~blue.
- Joystick half, when sel_p8_n=0: {p1..p4} = ~{up,down,left,right}; p6 half = ~fire1.
- Combining halves: each half is 1111/1 when its select is deasserted. Outputs are the AND of both halves, so both selects low is a wired-AND.
- Timing: ctrl_o and ctrl_p6_o are registered every clk_i cycle, not gated by clk_en_i. Latency is 1 cycle from select or joy change.
- Spinner accumulator, per port, signed ACC_W:
  - On spin_stb_i with spin_en_i=1, acc <= sat(acc + sext(spin_d_i)), saturating at ±(2^(ACC_W-1)-1).
  - A strobe in the same cycle as a step engine decrement applies both: acc + d - sign(acc), then saturates.
- Step engine:
  - Tick counter counts clk_en_i pulses 0..STEP_DIV-1 and wraps.
  - At wrap with acc>0: phase advances forward 11->10->00->01->11 and acc decrements by 1.
  - At wrap with acc<0: phase steps reverse and acc increments by 1.
  - At wrap with acc=0: phase holds.
  - Exactly one Gray step per wrap; no double edges.
- Output mapping: p7 = phase[1], p9 = phase[0].
- Spinner disable: spin_en_i=0 clears acc and the tick counter on the next cycle and forces phase to 11. Strobes are ignored while disabled.
- Boundaries:
  - Saturation never wraps sign.
  - STEP_DIV wrap with clk_en_i low does nothing.
  - A mid-step async reset returns the phase to 11 immediately.

Decomposition:
- Package cv_ctrl_pkg holds:
  - Key code localparams (cv_key_*_c).
  - Joystick bit index constants (JB_RIGHT..JB_BLUE).
  - Quadrature next/prev phase functions.
- Sub-module cv_spinner_quad: one per port via generate, containing the accumulator, tick counter and phase register.
- The keypad encoder stays in cv_ctrl_ports.

Test Plan:
- Keypad priority: sel_p5_n=0, sel_p8_n=1, joy bits 9 and 17 set (digits 1 and 9) -> next cycle ctrl_o=1110, p6=1. Then blue only -> ctrl_o=0010, p6=0.
- Joystick half: sel_p8_n=0, sel_p5_n=1, up+fire1 -> ctrl_o=0111, p6=0. Both selects low with digit 0 + up -> ctrl_o=0011, p6=1.
- Swap: NUM_PORTS=2, digit 5 on port 1 only, swap_i=1, port 0 keypad selected -> port 0 ctrl_o=1001, port 1 ctrl_o=1111.
- Spinner forward: STEP_DIV=4, clk_en every cycle, strobe +3 -> p7/p9 sequence 11,10,00,01 at 4-cycle spacing, then holds at 01, acc=0.
- Spinner reverse with saturation: ACC_W=8, strobes -100, -100 -> acc=-127. First step moves phase 11->01. Deassert spin_en_i -> acc=0, p7=p9=1 next cycle.
- Reset: assert reset_n_i low mid-sequence asynchronously -> all outputs 1 without a clock edge; after release, outputs are idle until a strobe arrives.
